// File: rtl/imem_fetch_unit.sv
// imem_fetch_unit: byte-addressed instruction memory with a byte-serial
// program-load port and a one-cycle-latency request/valid fetch port.
// Instructions are little-endian: the byte at the lower address is the low byte.
// Optional feature macro: IMEM_HALT_DETECT_EN enables HALT detection
// (a fetched HALT_WORD sets the sticky halted flag and stops fetching).
module imem_fetch_unit #(
  parameter int DEPTH_BYTES     = 64,
  parameter int ADDR_W          = 16,
  parameter int BYTES_PER_INSTR = 2,
  parameter logic [8*BYTES_PER_INSTR-1:0] HALT_WORD = 16'hF000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           load_start,
  input  logic                           load_valid,
  input  logic [7:0]                     load_byte,
  input  logic                           load_last,
  output logic                           load_ovf,
  output logic                           fetch_ready,
  input  logic                           fetch_req,
  input  logic [ADDR_W-1:0]              fetch_addr,
  output logic                           fetch_valid,
  output logic [8*BYTES_PER_INSTR-1:0]   fetch_instr,
  output logic                           fetch_fault,
  output logic                           halted
);

  localparam int INSTR_W = 8 * BYTES_PER_INSTR;
  localparam int MEM_AW  = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  // Load pointer must be able to hold DEPTH_BYTES itself (the "full" value).
  localparam int PTR_W   = $clog2(DEPTH_BYTES + 1);
  localparam logic [PTR_W-1:0]  DEPTH_PTR = PTR_W'(DEPTH_BYTES);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH_BYTES);
  localparam logic [ADDR_W:0]   BPI_EXT   = (ADDR_W + 1)'(BYTES_PER_INSTR);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BYTES_PER_INSTR - 1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_RUN,
    S_HALTED
  } state_t;

  // Storage: contents survive reset and load_start; never initialised.
  logic [7:0]         mem [DEPTH_BYTES];

  state_t             state_q;
  logic [PTR_W-1:0]   load_ptr_q;
  logic               load_ovf_q;
  logic               fetch_valid_q;
  logic               fetch_fault_q;
  logic [INSTR_W-1:0] fetch_instr_q;

  logic               mem_we_c;
  logic [MEM_AW-1:0]  rd_base_c;
  logic [INSTR_W-1:0] rd_word_c;
  logic [ADDR_W:0]    end_addr_c;
  logic               misalign_c;
  logic               range_c;
  logic               fault_c;

  // A byte is stored only while loading, when not overridden by load_start,
  // and only while the pointer is still inside the array.
  assign mem_we_c = (state_q == S_LOAD) && load_valid && !load_start &&
                    (load_ptr_q < DEPTH_PTR);

  // Fault decode depends on the address alone, so undefined memory contents
  // can never turn into a spurious fault. End address uses one extra bit.
  assign end_addr_c = {1'b0, fetch_addr} + BPI_EXT;
  assign misalign_c = (fetch_addr & ALIGN_MASK) != '0;
  assign range_c    = end_addr_c > DEPTH_EXT;
  assign fault_c    = misalign_c | range_c;

  assign rd_base_c  = fetch_addr[MEM_AW-1:0];

  // Gather the little-endian instruction word; the response register below
  // captures it, giving the one-cycle read latency.
  generate
    for (genvar gi = 0; gi < BYTES_PER_INSTR; gi++) begin : g_rd_lane
      assign rd_word_c[gi*8 +: 8] = mem[rd_base_c + MEM_AW'(gi)];
    end
  endgenerate

  // Program-load write port.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[load_ptr_q[MEM_AW-1:0]] <= load_byte;
    end
  end

`ifdef IMEM_HALT_DETECT_EN
  logic halted_q;
  logic halt_hit_c;

  // Decoded from the word being captured so halted rises with fetch_valid.
  assign halt_hit_c = !fault_c && (rd_word_c == HALT_WORD);
  assign halted     = halted_q;
`else
  assign halted     = 1'b0;
`endif

  // Control FSM: load sequencing, fetch acceptance and the response register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_LOAD;
      load_ptr_q    <= '0;
      load_ovf_q    <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_fault_q <= 1'b0;
      fetch_instr_q <= '0;
`ifdef IMEM_HALT_DETECT_EN
      halted_q      <= 1'b0;
`endif
    end else begin
      // Responses last exactly one cycle; data/fault hold afterwards.
      fetch_valid_q <= 1'b0;
      if (load_start) begin
        // Restart wins over any load byte or fetch request this cycle.
        state_q    <= S_LOAD;
        load_ptr_q <= '0;
        load_ovf_q <= 1'b0;
`ifdef IMEM_HALT_DETECT_EN
        halted_q   <= 1'b0;
`endif
      end else begin
        unique case (state_q)
          S_LOAD: begin
            if (load_valid) begin
              if (load_ptr_q < DEPTH_PTR) begin
                load_ptr_q <= load_ptr_q + 1'b1;
              end else begin
                load_ovf_q <= 1'b1;
              end
              if (load_last) begin
                state_q <= S_RUN;
              end
            end
          end
          S_RUN: begin
            if (fetch_req) begin
              fetch_valid_q <= 1'b1;
              fetch_fault_q <= fault_c;
              fetch_instr_q <= fault_c ? '0 : rd_word_c;
`ifdef IMEM_HALT_DETECT_EN
              if (halt_hit_c) begin
                halted_q <= 1'b1;
                state_q  <= S_HALTED;
              end
`endif
            end
          end
          default: begin
            // HALTED: ignore everything until load_start or rst.
          end
        endcase
      end
    end
  end

  assign fetch_ready = (state_q == S_RUN);
  assign fetch_valid = fetch_valid_q;
  assign fetch_instr = fetch_instr_q;
  assign fetch_fault = fetch_fault_q;
  assign load_ovf    = load_ovf_q;

endmodule

// File: doc/imem_fetch_unit.md
# imem_fetch_unit

Parametrised, byte-addressed instruction memory with a program-load port and a request/valid fetch port. Instructions are stored little-endian, so the byte at the lower address is the low byte. After reset the block loads a program byte by byte. It then serves one-cycle-latency instruction fetches to the fetch stage, with alignment/range fault reporting and optional HALT detection.

## Interface
- `DEPTH_BYTES`, 64: memory size in bytes (≥ `BYTES_PER_INSTR`).
- `ADDR_W`, 16: width of the fetch address.
- `BYTES_PER_INSTR`, 2: bytes per instruction; must be a power of two; `INSTR_W` = 8*`BYTES_PER_INSTR`.
- `HALT_WORD`, 16'hF000: instruction encoding treated as HALT (`INSTR_W` bits).
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `load_start` in 1: restart program load at byte 0.
- `load_valid` in 1: `load_byte` is valid this cycle.
- `load_byte` in 8: program byte.
- `load_last` in 1: qualifies `load_valid`; this is the final byte.
- `load_ovf` out 1: sticky; a byte was offered past `DEPTH_BYTES`.
- `fetch_ready` out 1: fetch requests are accepted this cycle.
- `fetch_req` in 1: fetch request.
- `fetch_addr` in `ADDR_W`: byte address of the instruction.
- `fetch_valid` out 1: response valid, one cycle after acceptance.
- `fetch_instr` out `INSTR_W`: fetched instruction.
- `fetch_fault` out 1: response is a fault (misaligned or out of range).
- `halted` out 1: sticky HALT seen (see Configuration).

## Operation
- States: LOAD, RUN, HALTED. Reset enters LOAD with `load_ptr`=0.
- LOAD:
  - `fetch_ready`=0.
  - A cycle with `load_valid` writes `load_byte` to `mem[load_ptr]` if `load_ptr` < `DEPTH_BYTES`, then increments `load_ptr`.
  - If `load_ptr` ≥ `DEPTH_BYTES`, the byte is dropped, `load_ovf` is set and `load_ptr` holds.
  - `load_valid`&`load_last` writes the byte (subject to the same bound) and moves to RUN.
- RUN:
  - `fetch_ready`=1. `load_valid` is ignored.
  - A fetch is accepted when `fetch_req`&`fetch_ready`.
  - The address is faulted when `fetch_addr` mod `BYTES_PER_INSTR` ≠ 0, or `fetch_addr` + `BYTES_PER_INSTR` > `DEPTH_BYTES` (compute with `ADDR_W`+1 bits, no wrap).
  - Fault response: `fetch_fault`=1 and `fetch_instr`=0.
  - Otherwise: `fetch_instr` = {mem[a+B-1], …, mem[a]}.
- `load_start` in any state: go to LOAD, `load_ptr`=0, clear `load_ovf` and `halted`. Memory contents are retained.
- `load_start` has priority over `load_valid` and `fetch_req` in the same cycle. A byte offered with `load_start` is not written.
- Reset:
  - Clears all state except the memory array, which is not initialised.
  - Reads of unwritten bytes return unspecified data, but never X-propagate a fault.

## Timing
- Reset values: `fetch_ready`=0, `fetch_valid`=0, `fetch_instr`=0, `fetch_fault`=0, `load_ovf`=0, `halted`=0.
- Fetch latency is 1 cycle: a request accepted at edge N gives `fetch_valid`=1 with data after edge N+1, for exactly one cycle. Back-to-back requests give a valid every cycle.
- `fetch_instr` and `fetch_fault` hold their last values when `fetch_valid`=0.
- A load byte written at edge N is fetchable by a request accepted at edge N+1 (after `load_last`).
- `load_start` or `rst` during a pending response: `fetch_valid` is 0 on the next cycle and the response is discarded.

## Configuration
- `IMEM_HALT_DETECT_EN` defined:
  - A non-faulting fetch returning `HALT_WORD` sets `halted`=1 in the same cycle `fetch_valid` rises.
  - The state moves to HALTED, where `fetch_ready`=0 and requests are ignored until `load_start` or `rst`.
- Not defined: `halted` is tied to 0, HALTED is unreachable, and `HALT_WORD` is returned as ordinary data.

## Test plan
- Load 20,0E,21,0B (last on 0B); fetch 0 then 2 back-to-back. Required: valid on consecutive cycles with 16'h0E20 then 16'h0B21, and no fault.
- Fetch address 1 and address 64 with `DEPTH_BYTES`=64. Required: each gives `fetch_valid`=1, `fetch_fault`=1, `fetch_instr`=0.
- Offer 65 load bytes. Required: `load_ovf`=1 after the 65th, and bytes 0–63 are intact on readback.
- `IMEM_HALT_DETECT_EN`: load 00,F0 at bytes 62–63 and fetch 62. Required: 16'hF000, `halted`=1, `fetch_ready`=0; a subsequent request produces no valid.
- Assert `rst` mid-load after 3 bytes, then reload 4 bytes. Required: `load_ptr` restarts at 0 and the fetch at 0 returns the new bytes.
- Assert `load_start` with `fetch_req` in RUN. Required: no `fetch_valid` next cycle, `fetch_ready`=0.
